// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// register offsets and STATUS/CTRL bit positions.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_t;

    localparam logic REG_TXDATA = 1'b0;
    localparam logic REG_CTRL   = 1'b1;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_EN_BIT    = 4;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Synchronous byte FIFO with occupancy count and single-cycle flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Bus-mapped transmit scheduler: buffers bytes in a FIFO and feeds them one at
// a time to a uart_tx core, with CTRL/STATUS registers and an idle interrupt.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        re,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        Tx_req,
    output logic [7:0]  Uart_data,
    input  logic        Tx_Active,
    input  logic        Tx_Done,
    output logic        irq,
    output tx_state_t   dbg_state
);

    logic          wr_txdata;
    logic          wr_ctrl;
    logic          rd_status;
    logic          flush;
    logic          launch;
    logic          ovf_set;
    logic          en;
    logic          ovf;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [31:0]   status_word;
    tx_state_t     state;
    logic          unused_wdata;

    assign wr_txdata    = cs && we && (addr == REG_TXDATA);
    assign wr_ctrl      = cs && we && (addr == REG_CTRL);
    assign rd_status    = cs && re && (addr == REG_CTRL);
    assign flush        = wr_ctrl && wdata[CTRL_FLUSH_BIT];
    assign unused_wdata = ^wdata[31:8];

    // Launch handshake with uart_tx: Tx_req is a one-cycle valid pulse that is
    // only issued while uart_tx reports !Tx_Active; the byte is considered
    // consumed on the Tx_Done pulse, after which one GAP cycle lets uart_tx
    // return to idle before the next launch may be considered.
    assign launch  = (state == ST_IDLE) && en && !empty && !Tx_Active;
    assign ovf_set = wr_txdata && full && !launch && !flush;
    assign irq     = en && empty && (state == ST_IDLE);
    assign dbg_state = state;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (launch),
        .flush (flush),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        status_word                            = '0;
        status_word[STAT_COUNT_LSB +: CW]      = count;
        status_word[STAT_EN_BIT]               = en;
        status_word[STAT_OVF_BIT]              = ovf;
        status_word[STAT_BUSY_BIT]             = (state != ST_IDLE);
        status_word[STAT_FULL_BIT]             = full;
        status_word[STAT_EMPTY_BIT]            = empty;
    end

    // Register file; an overflow in the same cycle as a STATUS read wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en    <= 1'b1;
            ovf   <= 1'b0;
            rdata <= '0;
        end else begin
            if (wr_ctrl) en <= wdata[CTRL_EN_BIT];
            if (ovf_set)        ovf <= 1'b1;
            else if (rd_status) ovf <= 1'b0;
            if (cs && re) rdata <= (addr == REG_CTRL) ? status_word : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            Tx_req    <= 1'b0;
            Uart_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state     <= ST_START;
                        Tx_req    <= 1'b1;
                        Uart_data <= fifo_dout;
                    end
                end
                ST_START: begin
                    state  <= ST_WAIT_DONE;
                    Tx_req <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    if (Tx_Done) state <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    Tx_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a behavioural uart_tx, a queue-based reference
// model of FIFO/register behaviour and a monitor comparing launches and reads.
module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0, we = 1'b0, re = 1'b0, addr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        Tx_req;
    logic [7:0]  Uart_data;
    logic        Tx_Active = 1'b0;
    logic        Tx_Done = 1'b0;
    logic        irq;
    tx_state_t   dbg_state;

    uart_tx_sched #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .Tx_req    (Tx_req),
        .Uart_data (Uart_data),
        .Tx_Active (Tx_Active),
        .Tx_Done   (Tx_Done),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: bytes accepted but not yet launched, in order.
    logic [7:0]  exp_q[$];
    logic [31:0] rd_exp_q[$];
    bit en_m = 1'b1, ovf_m = 1'b0, busy_m = 1'b0, gap_m = 1'b0;
    bit launch_now = 1'b0, prev_req = 1'b0, rd_edge = 1'b0;
    bit c_rst, c_wr_tx, c_wr_ctrl, c_rd_status, c_active, c_done;
    logic [31:0] c_wdata;
    int cyc = 0, last_done = -100, n_launch = 0;
    bit hold_active = 1'b0;
    int tx_cnt = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] w;
        w = '0;
        w[8 +: CW] = CW'(exp_q.size());
        w[4] = en_m;
        w[3] = ovf_m;
        w[2] = busy_m;
        w[1] = (exp_q.size() == DEPTH);
        w[0] = (exp_q.size() == 0);
        return w;
    endfunction

    // Behavioural uart_tx: accepts a launch, stays active 2..6 cycles, pulses done.
    initial forever begin
        @(negedge clk);
        if (hold_active) begin
            Tx_Active = 1'b1;
            Tx_Done   = 1'b0;
            tx_cnt    = 0;
        end else if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                Tx_Active = 1'b0;
                Tx_Done   = 1'b1;
            end
        end else begin
            Tx_Done   = 1'b0;
            Tx_Active = 1'b0;
            if (Tx_req) begin
                Tx_Active = 1'b1;
                tx_cnt    = $urandom_range(2, 6);
            end
        end
    end

    // Reference model: capture bus at the edge, update after the monitor.
    initial begin : model
        bit f, ov, exp_irq;
        forever begin
            @(posedge clk);
            cyc++;
            c_rst       = rst;
            c_wr_tx     = cs && we && !addr;
            c_wr_ctrl   = cs && we && addr;
            c_rd_status = cs && re && addr;
            c_wdata     = wdata;
            c_active    = Tx_Active;
            c_done      = Tx_Done;
            rd_edge     = rst && cs && re;
            if (rd_edge) rd_exp_q.push_back(addr ? status_m() : 32'h0);
            #2;
            if (!c_rst) begin
                exp_q.delete();
                rd_exp_q.delete();
                en_m = 1'b1; ovf_m = 1'b0; busy_m = 1'b0; gap_m = 1'b0;
            end else begin
                f  = c_wr_ctrl && c_wdata[1];
                ov = 1'b0;
                if (c_wr_tx && !f) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(c_wdata[7:0]);
                    else ov = 1'b1;
                end
                if (f) exp_q.delete();
                if (ov) ovf_m = 1'b1;
                else if (c_rd_status) ovf_m = 1'b0;
                if (c_wr_ctrl) en_m = c_wdata[0];
                if (launch_now) begin
                    busy_m = 1'b1; gap_m = 1'b0;
                end else if (gap_m) begin
                    busy_m = 1'b0; gap_m = 1'b0;
                end else if (busy_m && c_done) begin
                    gap_m = 1'b1;
                end
                if (c_done) last_done = cyc;
            end
            #1;
            exp_irq = en_m && (exp_q.size() == 0) && !busy_m;
            check(irq === exp_irq, "irq", 32'(irq), 32'(exp_irq));
        end
    end

    // Monitor: checks every launch and every read response.
    initial begin : monitor
        logic [7:0]  e8;
        logic [31:0] e32;
        bit ok;
        forever begin
            @(posedge clk);
            #1;
            launch_now = Tx_req;
            if (Tx_req) begin
                n_launch++;
                check(!prev_req, "tx_req_width", 32'(prev_req), 32'd0);
                ok = c_rst && en_m && (exp_q.size() != 0) && !busy_m && !c_active;
                check(ok, "launch_allowed", {en_m, busy_m, c_active}, 32'h4);
                check((cyc - last_done) >= 2, "launch_gap", 32'(cyc - last_done), 32'd2);
                if (exp_q.size() == 0) begin
                    check(1'b0, "launch_unexpected", 32'(Uart_data), 32'd0);
                end else begin
                    e8 = exp_q.pop_front();
                    check(Uart_data === e8, "uart_data", 32'(Uart_data), 32'(e8));
                end
            end
            prev_req = Tx_req;
            if (rd_edge) begin
                e32 = rd_exp_q.pop_front();
                check(rdata === e32, "rdata", rdata, e32);
            end
        end
    end

    task automatic bus_cycle(input logic c, input logic w, input logic r, input logic a, input logic [31:0] d);
        cs = c; we = w; re = r; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic wr_tx(input logic [31:0] d);   bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, d); endtask
    task automatic wr_ctrl(input logic [31:0] d); bus_cycle(1'b1, 1'b1, 1'b0, 1'b1, d); endtask
    task automatic bus_idle();                    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endtask

    task automatic rd_status(output logic [31:0] v);
        bus_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        v = rdata;
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && !busy_m && !Tx_Active && !Tx_Done) break;
            @(negedge clk);
        end
        check(i < max_cyc, "drain_timeout", 32'(i), 32'(max_cyc));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(Tx_req === 1'b0,      {tag, "_tx_req"},    32'(Tx_req),    32'd0);
        check(Uart_data === 8'h00,  {tag, "_uart_data"}, 32'(Uart_data), 32'd0);
        check(rdata === 32'h0,      {tag, "_rdata"},     rdata,          32'd0);
        check(irq === 1'b1,         {tag, "_irq"},       32'(irq),       32'd1);
        check(dbg_state == ST_IDLE, {tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] v, d;
        int base, r;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single byte: launch latency, pulse width and idle interrupt.
        wr_tx(32'h41);
        check(Tx_req === 1'b0, "lat_early", 32'(Tx_req), 32'd0);
        bus_idle();
        check(Tx_req === 1'b1, "lat_pulse", 32'(Tx_req), 32'd1);
        check(Uart_data === 8'h41, "lat_data", 32'(Uart_data), 32'h41);
        bus_idle();
        check(Tx_req === 1'b0, "lat_width", 32'(Tx_req), 32'd0);
        wait_idle(200);
        check(irq === 1'b1, "irq_after_done", 32'(irq), 32'd1);

        // Fill past capacity with launches disabled.
        wr_ctrl(32'h0);
        for (int i = 0; i < 9; i++) wr_tx(32'h20 + i);
        rd_status(v);
        check(v === 32'h0000_080A, "status_full_ovf", v, 32'h0000_080A);
        rd_status(v);
        check(v === 32'h0000_0802, "status_ovf_cleared", v, 32'h0000_0802);

        // Push in the same cycle as the pop from a full FIFO.
        wr_ctrl(32'h1);
        wr_tx(32'h99);
        rd_status(v);
        check(v === 32'h0000_0816, "push_on_pop", v, 32'h0000_0816);
        bus_idle();
        wait_idle(2000);

        // Four back-to-back bytes.
        base = n_launch;
        for (int i = 0; i < 4; i++) wr_tx(32'h10 + i);
        bus_idle();
        wait_idle(2000);
        check(n_launch - base == 4, "four_launches", 32'(n_launch - base), 32'd4);

        // Flush while waiting for the in-flight byte.
        base = n_launch;
        wr_tx(32'h55);
        wr_tx(32'h66);
        bus_idle();
        check(dbg_state == ST_WAIT_DONE, "flush_in_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
        wr_ctrl(32'h3);
        bus_idle();
        wait_idle(200);
        repeat (20) bus_idle();
        check(n_launch - base == 1, "flush_no_relaunch", 32'(n_launch - base), 32'd1);
        rd_status(v);
        check(v === 32'h0000_0011, "flush_status", v, 32'h0000_0011);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                wr_tx($urandom);
            end else if (r < 60) begin
                rd_status(v);
            end else if (r < 64) begin
                bus_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            end else if (r < 70) begin
                d = $urandom;
                d[1] = ($urandom_range(0, 9) == 0);
                d[0] = ($urandom_range(0, 3) != 0);
                wr_ctrl(d);
            end else begin
                bus_idle();
            end
        end
        wr_ctrl(32'h1);
        bus_idle();
        wait_idle(3000);

        // Reset mid-transfer with uart_tx still reporting active.
        wr_tx(32'h77);
        wr_tx(32'h78);
        bus_idle();
        hold_active = 1'b1;
        rst = 1'b0;
        bus_idle();
        bus_idle();
        check_reset_outputs("midreset");
        rst = 1'b1;
        base = n_launch;
        wr_tx(32'h5A);
        repeat (50) bus_idle();
        check(n_launch == base, "no_launch_while_active", 32'(n_launch - base), 32'd0);
        hold_active = 1'b0;
        wait_idle(200);
        check(n_launch - base == 1, "launch_after_release", 32'(n_launch - base), 32'd1);
        repeat (5) bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DEPTH, default 8, meaning: FIFO entries; a power of two, minimum 2.
REQ-002 Parameter CW, default 4, meaning: count width; equals log2(DEPTH)+1.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled only on clk rising edge.
REQ-005 cs  input  1  select from bus_arbiter UART decode.
REQ-006 we  input  1  write strobe; qualified by cs.
REQ-007 re  input  1  read strobe; qualified by cs.
REQ-008 addr  input  1  register select: 0 = TXDATA, 1 = CTRL/STATUS.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  registered read data.
REQ-011 Tx_req  output  1  one-cycle launch pulse to uart_tx i_Tx_DV.
REQ-012 Uart_data  output  8  byte to uart_tx i_Tx_Byte.
REQ-013 Tx_Active  input  1  from uart_tx o_Tx_Active.
REQ-014 Tx_Done  input  1  from uart_tx o_Tx_Done, a one-cycle pulse.
REQ-015 irq  output  1  high while enabled, FIFO empty and FSM IDLE.

Function
REQ-016 A TXDATA write (cs&we&addr=0) pushes wdata[7:0] when not full; when full, the byte is dropped and the sticky ovf bit is set.
REQ-017 A CTRL write (cs&we&addr=1) sets en=wdata[0]; wdata[1]=1 flushes the FIFO for one cycle, and that bit is not stored.
REQ-018 STATUS read: rdata = {16'b0, count[CW-1:0] at [15:8], 3'b0, en[4], ovf[3], busy[2], full[1], empty[0]}, valid the cycle after cs&re; a TXDATA read returns 0.
REQ-019 ovf is cleared by a STATUS read. If an overflow occurs in the same cycle, ovf stays 1.
REQ-020 FSM states are IDLE, START, WAIT_DONE and GAP. busy = (state != IDLE).
REQ-021 IDLE to START when en and !empty and !Tx_Active: pop the head into Uart_data and set Tx_req<=1.
REQ-022 START to WAIT_DONE unconditionally; Tx_req<=0, so Tx_req is high exactly one cycle.
REQ-023 WAIT_DONE to GAP on Tx_Done. GAP to IDLE after one cycle, which guarantees uart_tx returns to idle.
REQ-024 Latency: for a write sampled at edge E into an empty FIFO with FSM IDLE, Tx_req is high from E+1 to E+2.
REQ-025 Uart_data holds its value from launch until the next launch.
REQ-026 A simultaneous push and pop both take effect, and count is unchanged. A push to a full FIFO in the same cycle as a pop is accepted.
REQ-027 Read and write pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH); empty = (count==0).
REQ-028 Flush empties the FIFO but does not abort an in-flight byte. A push in the flush cycle is discarded.
REQ-029 Clearing en mid-transfer completes the current byte and blocks further launches; the FIFO contents are retained.

Reset
REQ-030 On rst=0 at a clk edge: state=IDLE, Tx_req=0, Uart_data=0, rdata=0, pointers=0, count=0, en=1, ovf=0.
REQ-031 Reset mid-transfer discards FIFO contents. Because uart_tx has no reset, no launch occurs after reset until Tx_Active is low (see REQ-021).

Structure
REQ-032 A shared package holds the FSM state encodings, the register-offset constants and the STATUS bit-position constants.
REQ-033 The FIFO is one sub-module, sync_fifo (parameters DEPTH and width 8; ports push, pop, flush, din, dout, count, full, empty). The FSM and register file live in uart_tx_sched.

Verification
REQ-034 Reset, then write 0x41 to TXDATA -> Tx_req is high for exactly one cycle one edge after the write with Uart_data=0x41; after Tx_Done plus one cycle, irq=1.
REQ-035 Write 9 bytes back-to-back (DEPTH=8) while en=0 -> STATUS reads count=8, full=1, ovf=1; a second STATUS read shows ovf=0.
REQ-036 Write 0x10..0x13 with en=1 -> exactly four Tx_req pulses with bytes in order 0x10,0x11,0x12,0x13; each pulse comes at least 2 cycles after the prior Tx_Done.
REQ-037 With FIFO full and a transfer launching, write in the pop cycle -> byte accepted, count stays 8, ovf=0.
REQ-038 During WAIT_DONE, write CTRL=0x3 (flush) -> the current byte completes, count=0, no further Tx_req.
REQ-039 Assert rst low mid-transfer with Tx_Active held high for 50 cycles -> no Tx_req until Tx_Active falls; all outputs at their reset values.
